alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational ALU (driven by a 4-bit ALU control code from the ALU control decode) between two requesters, e.g. the two issue slots of the execute stage. Arbitrates between requesters each cycle, drives the granted operation onto the ALU, and captures the result in a one-entry output register with valid/ready back-pressure. Sits between issue and the shared ALU; the result returns with requester id and tag for writeback routing.

## Interface
- DATA_W, 32, operand/result width
- TAG_W, 4, opaque requester tag width, returned unchanged
- clk  input  1  clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- req0_valid / req1_valid  input  1  request valid, per port
- req0_ready / req1_ready  output  1  request accepted this cycle, per port
- req0_ctrl / req1_ctrl  input  4  ALU control code; 4'b1111 = illegal
- req0_a, req0_b / req1_a, req1_b  input  DATA_W  operands
- req0_tag / req1_tag  input  TAG_W  requester tag
- alu_ctrl  output  4  control code to shared ALU
- alu_a, alu_b  output  DATA_W  operands to shared ALU
- alu_result  input  DATA_W  ALU result, combinational from alu_ctrl/alu_a/alu_b
- rsp_valid  output  1  output register holds a result
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  1  port that issued the result
- rsp_tag  output  TAG_W  tag of that request
- rsp_result  output  DATA_W  registered result; 0 when rsp_illegal
- rsp_illegal  output  1  request carried ctrl 4'b1111
- gnt_cnt0 / gnt_cnt1  output  16  accepted-request counters per port, saturating

## Operation
- can_accept = !rsp_valid | rsp_ready.
- Grant (combinational): one valid port -> that port; both valid -> arbitration policy (see Configuration); none -> no grant.
- reqN_ready = (grant == N) & can_accept; ready never asserts for a non-valid port and never for both ports.
- ALU drive: granted port's ctrl/a/b whenever a port is granted (even if !can_accept); no grant -> alu_ctrl = 4'b1111, alu_a = alu_b = 0.
- Accept (valid & ready on port N): next edge load rsp_valid=1, rsp_id=N, rsp_tag=reqN_tag, rsp_illegal=(ctrl==4'b1111), rsp_result = illegal ? 0 : alu_result.
- Drain: rsp_valid & rsp_ready with no accept -> rsp_valid=0 next edge; other rsp fields hold.
- Simultaneous drain and accept: new result loaded, rsp_valid stays 1 (full throughput).
- Stall: rsp_valid & !rsp_ready -> all rsp fields hold, both readys 0.
- Requesters must hold valid and payload stable until ready; the arbiter's grant may change while neither port is accepted.
- gnt_cntN increments by 1 on each port-N accept, sticks at 16'hFFFF.
- Round-robin pointer last_gnt (1 bit) updates to N on each port-N accept only.

## Timing
- Reset (rstn low, async): rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, rsp_illegal=0, last_gnt=1, gnt_cnt0=gnt_cnt1=0. req*_ready and alu_* follow combinationally from inputs (ready may be 1 in reset only if valid; no state updates until rstn high).
- Reset mid-operation discards any held result; no response for it is ever produced.
- Latency: accept edge -> rsp_valid high after 1 clock.
- Throughput: 1 request/cycle with rsp_ready held high.
- ALU path is combinational within the accept cycle; no ALU pipelining.

## Configuration
- ALU_ARB_RR_EN defined: both valid -> grant port != last_gnt (round-robin; first contended grant after reset goes to port 0). Neither port waits more than one accept of the other.
- ALU_ARB_RR_EN undefined: fixed priority, port 0 always wins contention; last_gnt register absent/unused, port 1 may starve.

## Test plan
- Reset: assert rstn=0 with rsp_valid=1 held -> all rsp outputs 0, gnt_cnt*=0 immediately, no response after release.
- Single port: req0 ctrl=ADD, a=5, b=7, tag=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_tag=3, rsp_result=12, gnt_cnt0=1.
- Contention with ALU_ARB_RR_EN: both ports valid 4 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1; without macro -> 0,0,0,0 and req1_ready stays 0.
- Back-pressure: rsp_ready=0 after one accept -> both readys 0, rsp fields stable 3 cycles; raise rsp_ready with req1 valid -> drain and accept same edge, rsp_valid stays 1, rsp_id=1.
- Illegal op: req1 ctrl=4'b1111, a=b=9 -> rsp_illegal=1, rsp_result=0, gnt_cnt1 increments.
- Saturation: force 65 540 accepts on port 0 -> gnt_cnt0 stops at 16'hFFFF, gnt_cnt1 unchanged.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU, with a one-entry
// valid/ready result register. Define ALU_ARB_RR_EN for round-robin contention.
module alu_arbiter #(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned TAG_W  = 4,
   localparam int unsigned CTRL_W = 4,
   localparam int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [TAG_W-1:0]  req0_tag,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [CTRL_W-1:0] req1_ctrl,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [TAG_W-1:0]  req1_tag,
   output logic [CTRL_W-1:0] alu_ctrl,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_illegal,
   output logic [CNT_W-1:0]  gnt_cnt0,
   output logic [CNT_W-1:0]  gnt_cnt1
);

   localparam logic [CTRL_W-1:0] CTRL_ILLEGAL = CTRL_W'(4'b1111);
   localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

   typedef struct packed {
      logic              id;
      logic [TAG_W-1:0]  tag;
      logic              illegal;
      logic [DATA_W-1:0] result;
   } rsp_t;

   logic             gnt_vld;
   logic             gnt_id;
   logic             can_accept;
   logic             accept;
   logic [TAG_W-1:0] sel_tag;
   rsp_t             rsp_d;
   rsp_t             rsp_q;

`ifdef ALU_ARB_RR_EN
   logic             last_gnt;
`endif

   // Grant selection: single requester wins outright, contention by policy
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_vld = 1'b1;
`ifdef ALU_ARB_RR_EN
         gnt_id  = ~last_gnt;
`else
         gnt_id  = 1'b0;
`endif
      end else if (req0_valid) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b0;
      end else if (req1_valid) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b1;
      end
   end

   assign can_accept = !rsp_valid || rsp_ready;
   assign accept     = gnt_vld && can_accept;
   assign req0_ready = accept && !gnt_id;
   assign req1_ready = accept && gnt_id;

   // Granted operation goes to the ALU even while the result register is stalled
   always_comb begin
      alu_ctrl = CTRL_ILLEGAL;
      alu_a    = '0;
      alu_b    = '0;
      sel_tag  = '0;
      if (gnt_vld) begin
         if (gnt_id) begin
            alu_ctrl = req1_ctrl;
            alu_a    = req1_a;
            alu_b    = req1_b;
            sel_tag  = req1_tag;
         end else begin
            alu_ctrl = req0_ctrl;
            alu_a    = req0_a;
            alu_b    = req0_b;
            sel_tag  = req0_tag;
         end
      end
   end

   always_comb begin
      rsp_d         = '0;
      rsp_d.id      = gnt_id;
      rsp_d.tag     = sel_tag;
      rsp_d.illegal = (alu_ctrl == CTRL_ILLEGAL);
      rsp_d.result  = rsp_d.illegal ? '0 : alu_result;
   end

   // Result register: load on accept, otherwise clear valid on drain
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_valid <= 1'b0;
         rsp_q     <= '0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_q     <= rsp_d;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   assign rsp_id      = rsp_q.id;
   assign rsp_tag     = rsp_q.tag;
   assign rsp_illegal = rsp_q.illegal;
   assign rsp_result  = rsp_q.result;

   // Saturating per-port accept counters
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else begin
         if (req0_ready && (gnt_cnt0 != CNT_MAX))
            gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
         if (req1_ready && (gnt_cnt1 != CNT_MAX))
            gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
      end
   end

`ifdef ALU_ARB_RR_EN
   // Reset to 1 so the first contended grant goes to port 0
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         last_gnt <= 1'b1;
      else if (accept)
         last_gnt <= gnt_id;
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a cycle-level
// behavioural model of the arbitration and result-register rules.
module tb_alu_arbiter;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned TAG_W  = 4;

   logic              clk = 1'b0;
   logic              rstn;
   logic              req0_valid, req1_valid;
   logic              req0_ready, req1_ready;
   logic [3:0]        req0_ctrl, req1_ctrl;
   logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [TAG_W-1:0]  req0_tag, req1_tag;
   logic [3:0]        alu_ctrl;
   logic [DATA_W-1:0] alu_a, alu_b, alu_result;
   logic              rsp_valid, rsp_ready, rsp_id, rsp_illegal;
   logic [TAG_W-1:0]  rsp_tag;
   logic [DATA_W-1:0] rsp_result;
   logic [15:0]       gnt_cnt0, gnt_cnt1;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit                m_valid, m_id, m_illegal, m_last;
   logic [TAG_W-1:0]  m_tag;
   logic [DATA_W-1:0] m_result;
   int                m_cnt [2];

   alu_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
      .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
      .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
      .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_illegal(rsp_illegal),
      .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] ref_alu(input logic [3:0] c,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return DATA_W'($signed(a) < $signed(b));
         4'b1100: return ~(a | b);
         default: return a ^ b;
      endcase
   endfunction

   assign alu_result = ref_alu(alu_ctrl, alu_a, alu_b);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic int model_grant();
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
         return m_last ? 0 : 1;
`else
         return 0;
`endif
      end
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_id = 0; m_illegal = 0; m_last = 1;
      m_tag = '0; m_result = '0; m_cnt[0] = 0; m_cnt[1] = 0;
   endtask

   task automatic check_rsp();
      check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      check("rsp_id", 64'(rsp_id), 64'(m_id));
      check("rsp_tag", 64'(rsp_tag), 64'(m_tag));
      check("rsp_result", 64'(rsp_result), 64'(m_result));
      check("rsp_illegal", 64'(rsp_illegal), 64'(m_illegal));
      check("gnt_cnt0", 64'(gnt_cnt0), 64'(m_cnt[0]));
      check("gnt_cnt1", 64'(gnt_cnt1), 64'(m_cnt[1]));
   endtask

   task automatic set_port(input int n, input bit v, input logic [3:0] c,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [TAG_W-1:0] t);
      if (n == 0) begin
         req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b; req0_tag = t;
      end else begin
         req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b; req1_tag = t;
      end
   endtask

   // One clock: called at negedge with inputs set, returns at next negedge
   task automatic cycle(input bit chk, output bit acc0, output bit acc1);
      int                g;
      bit                ca, rr;
      logic [3:0]        c;
      logic [DATA_W-1:0] a, b;
      logic [TAG_W-1:0]  t;
      #1;
      g  = model_grant();
      rr = rsp_ready;
      ca = !m_valid || rr;
      c = 4'hF; a = '0; b = '0; t = '0;
      if (g == 0) begin c = req0_ctrl; a = req0_a; b = req0_b; t = req0_tag; end
      if (g == 1) begin c = req1_ctrl; a = req1_a; b = req1_b; t = req1_tag; end
      acc0 = (g == 0) && ca;
      acc1 = (g == 1) && ca;
      if (chk) begin
         check("req0_ready", 64'(req0_ready), 64'(acc0));
         check("req1_ready", 64'(req1_ready), 64'(acc1));
         check("alu_ctrl", 64'(alu_ctrl), 64'(c));
         check("alu_a", 64'(alu_a), 64'(a));
         check("alu_b", 64'(alu_b), 64'(b));
      end
      @(posedge clk);
      if (acc0 || acc1) begin
         m_valid   = 1;
         m_id      = (g == 1);
         m_tag     = t;
         m_illegal = (c == 4'hF);
         m_result  = m_illegal ? '0 : ref_alu(c, a, b);
         if (m_cnt[g] < 65535) m_cnt[g]++;
         m_last    = (g == 1);
      end else if (m_valid && rr) begin
         m_valid = 0;
      end
      @(negedge clk);
      if (chk) check_rsp();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      model_reset();
      set_port(0, 0, 4'h0, '0, '0, '0);
      set_port(1, 0, 4'h0, '0, '0, '0);
      rsp_ready = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      bit a0, a1;
      bit rsp_seq [4];
      rstn = 1'b0;
      rsp_ready = 1'b0;
      model_reset();
      set_port(0, 0, 4'h0, '0, '0, '0);
      set_port(1, 0, 4'h0, '0, '0, '0);
      repeat (2) @(negedge clk);
      check_rsp();
      rstn = 1'b1;

      // Single port ADD
      rsp_ready = 1'b1;
      set_port(0, 1, 4'b0010, 32'd5, 32'd7, 4'd3);
      cycle(1, a0, a1);
      check("add_result", 64'(rsp_result), 64'd12);
      check("add_tag", 64'(rsp_tag), 64'd3);
      check("add_cnt0", 64'(gnt_cnt0), 64'd1);
      set_port(0, 0, 4'h0, '0, '0, '0);
      cycle(1, a0, a1);

      // Contention right after reset
      do_reset();
      rsp_ready = 1'b1;
      set_port(0, 1, 4'b0001, 32'h0F0, 32'h00F, 4'd1);
      set_port(1, 1, 4'b0110, 32'd50, 32'd8, 4'd2);
      for (int i = 0; i < 4; i++) begin
         cycle(1, a0, a1);
         rsp_seq[i] = rsp_id;
      end
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
         check("contend_id", 64'(rsp_seq[i]), 64'(i % 2));
`else
         check("contend_id", 64'(rsp_seq[i]), 64'd0);
`endif
      end

      // Back-pressure then simultaneous drain and accept
      set_port(1, 0, 4'h0, '0, '0, '0);
      set_port(0, 1, 4'b0000, 32'hFF00, 32'h0FF0, 4'd5);
      cycle(1, a0, a1);
      set_port(0, 0, 4'h0, '0, '0, '0);
      set_port(1, 1, 4'b0010, 32'd10, 32'd20, 4'd9);
      rsp_ready = 1'b0;
      repeat (3) cycle(1, a0, a1);
      check("stall_result", 64'(rsp_result), 64'h0F00);
      rsp_ready = 1'b1;
      cycle(1, a0, a1);
      check("drain_acc_valid", 64'(rsp_valid), 64'd1);
      check("drain_acc_id", 64'(rsp_id), 64'd1);
      check("drain_acc_result", 64'(rsp_result), 64'd30);

      // Illegal op on port 1
      set_port(1, 1, 4'b1111, 32'd9, 32'd9, 4'd7);
      cycle(1, a0, a1);
      check("illegal_flag", 64'(rsp_illegal), 64'd1);
      check("illegal_result", 64'(rsp_result), 64'd0);
      set_port(1, 0, 4'h0, '0, '0, '0);
      cycle(1, a0, a1);

      // Reset while a result is held
      rsp_ready = 1'b0;
      set_port(0, 1, 4'b0010, 32'd1, 32'd2, 4'd4);
      cycle(1, a0, a1);
      set_port(0, 0, 4'h0, '0, '0, '0);
      #2 rstn = 1'b0;
      model_reset();
      #1 check_rsp();
      @(negedge clk);
      rstn = 1'b1;
      rsp_ready = 1'b1;
      repeat (3) cycle(1, a0, a1);

      // Randomized traffic obeying hold-until-ready
      do_reset();
      a0 = 1; a1 = 1;
      for (int i = 0; i < 3000; i++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (!req0_valid || a0)
            set_port(0, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                     $urandom, $urandom, 4'($urandom_range(0, 15)));
         if (!req1_valid || a1)
            set_port(1, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                     $urandom, $urandom, 4'($urandom_range(0, 15)));
         cycle(1, a0, a1);
      end

      // Counter saturation on port 0
      do_reset();
      rsp_ready = 1'b1;
      set_port(0, 1, 4'b0010, 32'd3, 32'd4, 4'd1);
      for (int i = 0; i < 65540; i++)
         cycle(i >= 65530, a0, a1);
      check("sat_cnt0", 64'(gnt_cnt0), 64'hFFFF);
      check("sat_cnt1", 64'(gnt_cnt1), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
